// File: rtl/pipe_pkg.sv
// Shared widths and control-field bit positions for the pipelined MIPS core's
// inter-stage registers.
package pipe_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  // Default payload split for each stage boundary (data survives a bubble, ctrl does not).
  localparam int unsigned IF_ID_DATA_W  = 2 * WORD_W;
  localparam int unsigned IF_ID_CTRL_W  = 1;
  localparam int unsigned ID_EX_DATA_W  = 3 * WORD_W + 3 * REG_ADDR_W;
  localparam int unsigned ID_EX_CTRL_W  = 8;
  localparam int unsigned EX_MEM_DATA_W = 2 * WORD_W + REG_ADDR_W;
  localparam int unsigned EX_MEM_CTRL_W = 7;
  localparam int unsigned MEM_WB_DATA_W = 2 * WORD_W;
  localparam int unsigned MEM_WB_CTRL_W = 7;

  localparam int unsigned STAGE_DATA_W_DFLT = MEM_WB_DATA_W;
  localparam int unsigned STAGE_CTRL_W_DFLT = 8;
  localparam int unsigned STALL_CNT_W_DFLT  = 16;

  localparam int unsigned CTRL_REGWRITE = 0;
  localparam int unsigned CTRL_MEMTOREG = 1;
  localparam int unsigned CTRL_MEMWRITE = 2;
  localparam int unsigned CTRL_MEMREAD  = 3;
  localparam int unsigned CTRL_BRANCH   = 4;
  localparam int unsigned CTRL_ALUSRC   = 5;
  localparam int unsigned CTRL_REGDST   = 6;
  localparam int unsigned CTRL_JUMP     = 7;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc=1 and sticks at all-ones.
// Reusable for any performance counter in the core.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with flush, bubble control clearing
// and stall counter. Define PIPE_SKID_BUFFER_EN for a one-entry skid (registered ready).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = STAGE_DATA_W_DFLT,
  parameter int unsigned CTRL_W = STAGE_CTRL_W_DFLT,
  parameter int unsigned CNT_W  = STALL_CNT_W_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              in_fire, out_fire;

  assign out_fire = valid_q & out_ready;
  assign in_fire  = in_valid & in_ready;

`ifdef PIPE_SKID_BUFFER_EN
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

  // Ready depends only on skid occupancy, breaking the out_ready->in_ready path.
  assign in_ready = ~skid_valid_q & ~flush & ~rst;

  always_comb begin
    valid_d      = valid_q;
    data_d       = data_q;
    ctrl_d       = ctrl_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;
    if (flush) begin
      valid_d      = 1'b0;
      ctrl_d       = '0;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
    end else if (out_fire && skid_valid_q) begin
      data_d       = skid_data_q;
      ctrl_d       = skid_ctrl_q;
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
    end else if (in_fire) begin
      if (valid_q && !out_ready) begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
        skid_ctrl_d  = in_ctrl;
      end else begin
        valid_d = 1'b1;
        data_d  = in_data;
        ctrl_d  = in_ctrl;
      end
    end else if (out_fire) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
    end
  end
`else
  assign in_ready = (~valid_q | out_ready) & ~flush & ~rst;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (in_fire) begin
      valid_d = 1'b1;
      data_d  = in_data;
      ctrl_d  = in_ctrl;
    end else if (out_fire) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_ctrl  = ctrl_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (valid_q & ~out_ready),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg: streaming, back-pressure, bubble, flush,
// async reset and stall-counter saturation (CNT_W=4).
module tb_pipe_stage_reg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned CTRL_W = 8;
  localparam int unsigned CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  stall_cnt;

  int checksTotal  = 0;
  int checksPassed = 0;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checksTotal++;
    if (observed === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic vld, input logic [63:0] data, input logic [7:0] ctrl,
                               input logic ordy, input logic fl);
    in_valid  = vld;
    in_data   = data;
    in_ctrl   = ctrl;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 64'h0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_data", out_data, 0);
    checkOutput("reset_stall_cnt", stall_cnt, 0);
    rst = 1'b0;
    #1;
    checkOutput("post_reset_in_ready", in_ready, 1);

    // Streaming 0x11..0x15 back-to-back
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 64'h11 + 64'(i), 8'h81, 1'b1, 1'b0);
      checkOutput("stream_in_ready", in_ready, 1);
      tick();
      checkOutput("stream_out_valid", out_valid, 1);
      checkOutput("stream_out_data", out_data, 64'h11 + 64'(i));
      checkOutput("stream_out_ctrl", out_ctrl, 8'h81);
    end
    applyStimulus(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("stream_drain_valid", out_valid, 0);
    checkOutput("stream_drain_ctrl", out_ctrl, 0);
    checkOutput("stream_drain_data", out_data, 64'h15);
    checkOutput("stream_stall_cnt", stall_cnt, 0);

    // Back-pressure for 3 cycles
    applyStimulus(1'b1, 64'h20, 8'h03, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 64'h0, 8'h00, 1'b0, 1'b0);
`ifndef PIPE_SKID_BUFFER_EN
    #1;
    checkOutput("bp_in_ready_low", in_ready, 0);
`endif
    for (int i = 0; i < 3; i++) tick();
    checkOutput("bp_out_valid", out_valid, 1);
    checkOutput("bp_out_data", out_data, 64'h20);
    checkOutput("bp_stall_cnt", stall_cnt, 3);
    applyStimulus(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("bp_release_valid", out_valid, 0);
    checkOutput("bp_release_cnt", stall_cnt, 3);

`ifdef PIPE_SKID_BUFFER_EN
    // Skid: exactly one extra beat accepted under back-pressure, order preserved
    applyStimulus(1'b1, 64'h30, 8'h10, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 64'h31, 8'h11, 1'b0, 1'b0);
    checkOutput("skid_accept_ready", in_ready, 1);
    tick();
    applyStimulus(1'b1, 64'h32, 8'h12, 1'b0, 1'b0);
    checkOutput("skid_full_ready", in_ready, 0);
    tick();
    checkOutput("skid_hold_data", out_data, 64'h30);
    out_ready = 1'b1;
    tick();
    checkOutput("skid_drain1_data", out_data, 64'h31);
    checkOutput("skid_drain1_ctrl", out_ctrl, 8'h11);
    checkOutput("skid_ready_back", in_ready, 1);
    tick();
    checkOutput("skid_drain2_data", out_data, 64'h32);
    applyStimulus(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
    tick();
    checkOutput("skid_empty_valid", out_valid, 0);
`endif

    // Bubble after a beat with all control bits set
    applyStimulus(1'b1, 64'h40, 8'hFF, 1'b1, 1'b0);
    tick();
    checkOutput("bubble_beat_ctrl", out_ctrl, 8'hFF);
    applyStimulus(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("bubble_valid", out_valid, 0);
      checkOutput("bubble_ctrl", out_ctrl, 8'h00);
      checkOutput("bubble_data", out_data, 64'h40);
    end

    // Flush with the stage full and a new beat offered
    applyStimulus(1'b1, 64'h50, 8'h22, 1'b0, 1'b0);
    tick();
`ifdef PIPE_SKID_BUFFER_EN
    applyStimulus(1'b1, 64'h5A, 8'h23, 1'b0, 1'b0);
    tick();
`endif
    applyStimulus(1'b1, 64'h51, 8'h24, 1'b0, 1'b1);
    checkOutput("flush_in_ready", in_ready, 0);
    tick();
    checkOutput("flush_valid", out_valid, 0);
    checkOutput("flush_ctrl", out_ctrl, 8'h00);
    checkOutput("flush_data", out_data, 64'h50);
    applyStimulus(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
    #1;
    checkOutput("flush_ready_after", in_ready, 1);
    tick();
    checkOutput("flush_nothing_left", out_valid, 0);

    // Asynchronous reset mid-stream with a beat pending
    applyStimulus(1'b1, 64'h70, 8'h0C, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 64'h71, 8'h0D, 1'b0, 1'b0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", out_valid, 0);
    checkOutput("async_rst_ctrl", out_ctrl, 0);
    checkOutput("async_rst_data", out_data, 0);
    checkOutput("async_rst_cnt", stall_cnt, 0);
    checkOutput("async_rst_ready", in_ready, 0);
    tick();
    checkOutput("async_rst_ready_hold", in_ready, 0);
    applyStimulus(1'b0, 64'h0, 8'h00, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("async_rst_release_ready", in_ready, 1);
    tick();
    checkOutput("async_rst_no_beat", out_valid, 0);

    // Stall counter saturation at 15, unaffected by flush
    applyStimulus(1'b1, 64'h60, 8'h01, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 64'h0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) tick();
    checkOutput("sat_cnt_14", stall_cnt, 14);
    for (int i = 0; i < 6; i++) tick();
    checkOutput("sat_cnt_15", stall_cnt, 15);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("sat_flush_valid", out_valid, 0);
    checkOutput("sat_after_flush", stall_cnt, 15);
    tick();
    checkOutput("sat_hold", stall_cnt, 15);

    $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic parametrised pipeline stage register with valid/ready handshake, stall back-pressure, flush and bubble insertion.
- Successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB); every stage boundary of the pipelined MIPS core instantiates it.
- Payload is split into data, which holds its value on a bubble, and control, which is forced to 0 on a bubble so that RegWrite/MemWrite never fire from an invalid slot.
- Includes a saturating stall-cycle counter for performance analysis.

Parameters:
- DATA_W, 64, payload bits not cleared on bubble (e.g. ALUResult plus ReadData).
- CTRL_W, 8, control bits forced to 0 whenever the stage holds no valid beat.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous squash of the stage contents
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat
- in_data  in  DATA_W  upstream data
- in_ctrl  in  CTRL_W  upstream control
- out_valid  out  1  downstream beat valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  registered data
- out_ctrl  out  CTRL_W  registered control; 0 when out_valid=0
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_ctrl=0, stall_cnt=0, internal skid entry empty. in_ready=0 while rst=1.
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_valid may assert independently of in_ready.
  - Producer holds in_data/in_ctrl stable until in_fire (bench-checked, not enforced).
- Latency and throughput: 1 cycle from in_fire to out_valid. Sustained throughput is 1 beat/cycle when out_ready=1.
- Main register update, without flush:
  - in_fire and the main slot is free or drains this cycle: load in_data/in_ctrl, out_valid<=1.
  - out_fire and no replacement beat: out_valid<=0 and out_ctrl<=0; out_data holds its last value.
  - Neither event: all outputs hold.
  - out_fire and in_fire in the same cycle: the new beat replaces the old one and out_valid stays 1.
- Flush, highest priority after rst:
  - On the next edge: out_valid<=0, out_ctrl<=0, skid entry emptied; out_data holds.
  - in_ready=0 during the flush cycle, so no beat is accepted.
  - A flush concurrent with out_fire is legal; that beat counts as delivered.
- Stall counter:
  - Increments when out_valid & !out_ready.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Unaffected by flush; cleared only by rst.
- Reset mid-operation: all state clears immediately (asynchronous), including any beat held in the skid entry.

Optional Feature:
- Macro: PIPE_SKID_BUFFER_EN.
- Defined:
  - Adds a one-entry skid register (data, ctrl, valid).
  - in_ready = !skid_valid & !flush & !rst. The ready path is registered, so there is no combinational out_ready->in_ready path.
  - If in_fire occurs while main is valid and out_ready=0, the beat goes to skid.
  - On out_fire with skid valid: main<=skid, skid empties, and in_ready returns 1 the next cycle.
  - Maximum occupancy is 2 beats.
- Undefined:
  - No skid entry.
  - in_ready = (!out_valid | out_ready) & !flush & !rst. This is combinational from out_ready.
  - Maximum occupancy is 1 beat.
- In both configurations the observable beat order and values are identical; only ready timing differs.

Decomposition:
- Package pipe_pkg holds:
  - WORD_W=32, REG_ADDR_W=5.
  - Default DATA_W/CTRL_W per stage boundary (MEM_WB_DATA_W=64, MEM_WB_CTRL_W=7, ...).
  - Bit-index constants for control fields (CTRL_REGWRITE, CTRL_MEMTOREG, ...).
- Sub-module sat_counter (parameter W; inputs clk, rst, inc; output cnt) implements stall_cnt. It is reusable for other performance counters.

Test Plan:
- Reset: assert rst mid-stream with a beat pending → out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0 the same cycle; in_ready=0 until rst drops.
- Streaming: out_ready=1; send in_data=0x11..0x15 back-to-back with in_ctrl=0x81 → out_data=0x11..0x15 one cycle later each, out_valid continuous, stall_cnt=0.
- Back-pressure:
  - Drop out_ready for 3 cycles while out_valid=1 → out_data holds, stall_cnt=3.
  - With PIPE_SKID_BUFFER_EN: exactly 1 extra beat is accepted, then in_ready=0; after release, beats drain in order with none lost.
- Bubble: in_valid=0 for 2 cycles after a beat with in_ctrl=0xFF → out_ctrl=0x00 and out_valid=0 after the drain; out_data retains the last value.
- Flush: stage holds 2 beats (skid build) and flush=1 with in_valid=1 → next cycle out_valid=0, out_ctrl=0, the incoming beat is dropped, and in_ready=1 the following cycle.
- Saturation: CNT_W=4 with out_ready=0 for 20 cycles while valid → stall_cnt stops at 15; a flush leaves it at 15.
